// File: rtl/fpga_clk_rst_pkg.sv
// Shared definitions for the FPGA clock/reset sequencer.
//   state_t     : sequencer states HOLD / STRETCH / RELEASE / RUN
//   SYNC_STAGES : depth of every synchroniser in the block
//   clog2()     : index width helper, never returns less than 1
package fpga_clk_rst_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_STRETCH = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/fpga_sync_2ff.sv
// Generic multi-flop synchroniser (SYNC_STAGES deep) with a selectable
// reset value. Used for lock, board reset and software request paths.
// For a reset synchroniser tie d_i low and set RST_VAL=1: the output
// asserts asynchronously and clears SYNC_STAGES cycles after rst_i drops.
//   clk_i : destination clock
//   rst_i : asynchronous active-high reset
//   d_i   : asynchronous input
//   q_o   : synchronised output
module fpga_sync_2ff
    import fpga_clk_rst_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/fpga_clk_rst_seq.sv
// FPGA clock/reset block: synchronises the board reset and the PLL lock,
// stretches reset, then releases NUM_RST domains in ascending order with
// GAP_CYC cycles between releases. Also produces NUM_CE clock-enable
// strobes, ce_out[k] with period 2^((k+1)*CE_STEP), once rst_done is high.
// Optional feature macro: SW_RST_EN (software reset via sw_rst_req).
//   fpga_clk_in  : single clock for all logic
//   fpga_rst_in  : asynchronous active-high board reset
//   pll_locked   : lock indication, asynchronous
//   sw_rst_req   : software reset request (used only with SW_RST_EN)
//   fpga_rst_out : per-domain active-high reset, registered
//   rst_done     : every domain released
//   ce_out       : single-cycle clock-enable strobes
//   fsm_state    : sequencer state, for debug/observation
module fpga_clk_rst_seq
    import fpga_clk_rst_pkg::*;
#(
    parameter int NUM_RST     = 3,
    parameter int STRETCH_CYC = 16,
    parameter int GAP_CYC     = 4,
    parameter int NUM_CE      = 2,
    parameter int CE_STEP     = 2,
    parameter int CNT_W       = 8
) (
    input  logic               fpga_clk_in,
    input  logic               fpga_rst_in,
    input  logic               pll_locked,
    input  logic               sw_rst_req,
    output logic [NUM_RST-1:0] fpga_rst_out,
    output logic               rst_done,
    output logic [NUM_CE-1:0]  ce_out,
    output logic [1:0]         fsm_state
);

    localparam int IDX_W = clog2(NUM_RST);
    localparam int CE_W  = NUM_CE * CE_STEP;

    logic rst_s;
    logic lock_s;
    logic sw_rise;

    fpga_sync_2ff #(.RST_VAL(1'b1)) u_rst_sync (
        .clk_i (fpga_clk_in),
        .rst_i (fpga_rst_in),
        .d_i   (1'b0),
        .q_o   (rst_s)
    );

    fpga_sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
        .clk_i (fpga_clk_in),
        .rst_i (fpga_rst_in),
        .d_i   (pll_locked),
        .q_o   (lock_s)
    );

`ifdef SW_RST_EN
    logic sw_s;
    logic sw_prev_q;

    fpga_sync_2ff #(.RST_VAL(1'b0)) u_sw_sync (
        .clk_i (fpga_clk_in),
        .rst_i (fpga_rst_in),
        .d_i   (sw_rst_req),
        .q_o   (sw_s)
    );

    always_ff @(posedge fpga_clk_in or posedge fpga_rst_in) begin
        if (fpga_rst_in) begin
            sw_prev_q <= 1'b0;
        end else begin
            sw_prev_q <= sw_s;
        end
    end

    assign sw_rise = sw_s & ~sw_prev_q;
`else
    // Request input is kept on the port but has no effect in this build.
    assign sw_rise = sw_rst_req & 1'b0;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_RST-1:0] rst_out_q, rst_out_d;
    logic               done_q, done_d;
    logic [CE_W-1:0]    ce_cnt_q, ce_cnt_d;
    logic [NUM_CE-1:0]  ce_q, ce_d;

    // Next-state logic. Lock loss (and a software request in RELEASE/RUN)
    // overrides every state, so it also wins over a release due this cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rst_out_d = rst_out_q;
        done_d    = done_q;

        if (!lock_s ||
            (sw_rise && (state_q == ST_RELEASE || state_q == ST_RUN))) begin
            state_d   = ST_HOLD;
            cnt_d     = '0;
            idx_d     = '0;
            rst_out_d = '1;
            done_d    = 1'b0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    rst_out_d = '1;
                    done_d    = 1'b0;
                    cnt_d     = '0;
                    idx_d     = '0;
                    if (!rst_s) begin
                        state_d = ST_STRETCH;
                    end
                end
                ST_STRETCH: begin
                    if (cnt_q == CNT_W'(STRETCH_CYC - 1)) begin
                        state_d = ST_RELEASE;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    // The domain drops on the first cycle of its slot; the
                    // remaining GAP_CYC-1 cycles of the slot are spacing.
                    if (cnt_q == '0) begin
                        rst_out_d[idx_q] = 1'b0;
                    end
                    if (idx_q == IDX_W'(NUM_RST - 1)) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                        cnt_d = '0;
                        idx_d = idx_q + IDX_W'(1);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    done_d = 1'b1;
                end
                default: begin
                    state_d = ST_HOLD;
                end
            endcase
        end
    end

    // Clock-enable divider: counts only while done stays high, so the
    // first ce_out[0] strobe lands 2^CE_STEP cycles after rst_done rises.
    always_comb begin
        logic [CE_W-1:0] mask;
        mask = '0;
        ce_d = '0;
        if (done_q && done_d) begin
            ce_cnt_d = ce_cnt_q + CE_W'(1);
        end else begin
            ce_cnt_d = '0;
        end
        for (int k = 0; k < NUM_CE; k++) begin
            mask    = CE_W'((64'd1 << ((k + 1) * CE_STEP)) - 64'd1);
            ce_d[k] = done_q && done_d && ((ce_cnt_q & mask) == mask);
        end
    end

    always_ff @(posedge fpga_clk_in or posedge fpga_rst_in) begin
        if (fpga_rst_in) begin
            state_q   <= ST_HOLD;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_out_q <= '1;
            done_q    <= 1'b0;
            ce_cnt_q  <= '0;
            ce_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rst_out_q <= rst_out_d;
            done_q    <= done_d;
            ce_cnt_q  <= ce_cnt_d;
            ce_q      <= ce_d;
        end
    end

    assign fpga_rst_out = rst_out_q;
    assign rst_done     = done_q;
    assign ce_out       = ce_q;
    assign fsm_state    = state_q;

endmodule
